// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD converter:
//   state_t   - converter FSM state encoding
//   BCD_NINE  - digit value used when saturating on overflow
//   add3_adj  - double-dabble digit correction (add 3 when digit >= 5)
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    // A digit >= 5 would become >= 10 after the next doubling; pre-adding 3
    // makes the doubling carry into the next digit instead.
    function automatic logic [3:0] add3_adj(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational shift-and-add-3 correction for one BCD digit.
// Ports:
//   i_digit  in   4  current BCD digit
//   o_digit  out  4  digit after the add-3 correction
// ----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = add3_adj(i_digit);

endmodule

// File: rtl/bin2bcd_pipe.sv
// ----------------------------------------------------------------------------
// bin2bcd_pipe
// Handshaked sequential binary-to-BCD converter (shift-and-add-3, one input
// bit per clock) with overflow saturation and a leading-zero blanking mask.
// Parameters:
//   BIN_W  binary input width (4..32)
//   DIG_N  number of BCD output digits (1..10)
// Ports:
//   sys_clk    in   1        clock, rising edge
//   sys_rst_n  in   1        synchronous active-low reset
//   in_valid   in   1        in_data valid
//   in_ready   out  1        converter idle and able to accept
//   in_data    in   BIN_W    unsigned binary value
//   out_valid  out  1        result valid, held until out_ready
//   out_ready  in   1        consumer accepts result
//   bcd_data   out  4*DIG_N  packed BCD, digit 0 least significant
//   digit_nz   out  DIG_N    bit i set if digit i or any higher digit != 0
//   ovf        out  1        input exceeded 10^DIG_N-1, bcd_data saturated
// ----------------------------------------------------------------------------
module bin2bcd_pipe
    import bcd_pkg::*;
#(
    parameter int BIN_W = 20,
    parameter int DIG_N = 6
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_W-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*DIG_N-1:0]   bcd_data,
    output logic [DIG_N-1:0]     digit_nz,
    output logic                 ovf
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int BCD_W = 4 * DIG_N;
    localparam int SR_W  = BCD_W + BIN_W;

    state_t             r_state;
    state_t             w_state_next;

    logic [BCD_W-1:0]   r_bcd_sr;
    logic [BIN_W-1:0]   r_bin_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    logic [BCD_W-1:0]   r_bcd_out;
    logic               r_ovf_out;
    logic               r_out_valid;

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [SR_W-1:0]    w_shifted;
    logic               w_shift_out;
    logic               w_last;
    logic               w_ovf_next;
    logic [DIG_N-1:0]   w_nz_chain;

    // ------------------------------------------------------------------
    // Per-digit add-3 correction
    // ------------------------------------------------------------------
    for (genvar g = 0; g < DIG_N; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_bcd_sr[4*g +: 4]),
            .o_digit (w_bcd_adj[4*g +: 4])
        );
    end

    // The bit leaving the top digit is lost precision, i.e. overflow.
    assign {w_shift_out, w_shifted} = {w_bcd_adj, r_bin_sr, 1'b0};
    assign w_last     = (r_cnt == CNT_W'(BIN_W - 1));
    assign w_ovf_next = r_ovf | w_shift_out;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = SHIFT;
            SHIFT:   if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b0;
        if (r_state == IDLE) begin
            in_ready = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_bcd_sr    <= '0;
            r_bin_sr    <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_bcd_out   <= '0;
            r_ovf_out   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bin_sr <= in_data;
                        r_bcd_sr <= '0;
                        r_ovf    <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_bcd_sr <= w_shifted[SR_W-1:BIN_W];
                    r_bin_sr <= w_shifted[BIN_W-1:0];
                    r_ovf    <= w_ovf_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_bcd_out   <= w_ovf_next ? {DIG_N{BCD_NINE}}
                                                  : w_shifted[SR_W-1:BIN_W];
                        r_ovf_out   <= w_ovf_next;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero mask: OR-chain from the top digit down; digit 0 is
    // always shown so a zero value still displays "0".
    // ------------------------------------------------------------------
    assign w_nz_chain[DIG_N-1] = |r_bcd_out[BCD_W-1 -: 4];
    for (genvar g = 0; g < DIG_N - 1; g++) begin : g_nz
        assign w_nz_chain[g] = w_nz_chain[g+1] | (|r_bcd_out[4*g +: 4]);
    end

    assign digit_nz  = w_nz_chain | DIG_N'(1);
    assign bcd_data  = r_bcd_out;
    assign ovf       = r_ovf_out;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bin2bcd_pipe.sv
// ----------------------------------------------------------------------------
// tb_bin2bcd_pipe
// Self-checking bench for bin2bcd_pipe: a default (20-bit, 6-digit) instance
// and a small (8-bit, 2-digit) instance. Expected results come from a
// divide-by-ten reference model and travel through scoreboard queues.
// ----------------------------------------------------------------------------
module tb_bin2bcd_pipe;

    typedef struct {
        logic [39:0] bcd;
        logic [9:0]  nz;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;

    // default instance
    logic        iv, ir, ov, ordy, ovf;
    logic [19:0] id;
    logic [23:0] bcd;
    logic [5:0]  nz;

    // small instance
    logic        iv8, ir8, ov8, ordy8, ovf8;
    logic [7:0]  id8;
    logic [7:0]  bcd8;
    logic [1:0]  nz8;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t q[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    bin2bcd_pipe #(.BIN_W(20), .DIG_N(6)) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .in_data   (id),
        .out_valid (ov),
        .out_ready (ordy),
        .bcd_data  (bcd),
        .digit_nz  (nz),
        .ovf       (ovf)
    );

    bin2bcd_pipe #(.BIN_W(8), .DIG_N(2)) u_dut8 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .in_data   (id8),
        .out_valid (ov8),
        .out_ready (ordy8),
        .bcd_data  (bcd8),
        .digit_nz  (nz8),
        .ovf       (ovf8)
    );

    function automatic exp_t model(input longint unsigned v, input int unsigned dig);
        exp_t e;
        longint unsigned lim = 1;
        longint unsigned t;
        e.bcd = '0;
        e.nz  = '0;
        for (int unsigned i = 0; i < dig; i++) lim = lim * 10;
        e.ovf = (v >= lim);
        t = e.ovf ? lim - 1 : v;
        for (int unsigned i = 0; i < dig; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        for (int unsigned i = 0; i < dig; i++) e.nz[i] = ((e.bcd >> (4*i)) != 40'd0);
        e.nz[0] = 1'b1;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a value, wait (bounded) for in_ready, complete the handshake,
    // then scramble in_data to show it is only sampled at the handshake.
    task automatic send(input int sel, input longint unsigned v);
        int n = 0;
        if (sel == 0) begin
            iv = 1'b1; id = 20'(v);
            while (ir !== 1'b1 && n < 200) begin tick(); n++; end
            chk("send_ready", 64'(ir), 64'd1);
            tick();
            iv = 1'b0; id = ~id;
            q.push_back(model(v, 6));
        end else begin
            iv8 = 1'b1; id8 = 8'(v);
            while (ir8 !== 1'b1 && n < 200) begin tick(); n++; end
            chk("send8_ready", 64'(ir8), 64'd1);
            tick();
            iv8 = 1'b0; id8 = ~id8;
            q8.push_back(model(v, 2));
        end
    endtask

    // Called right after the handshake edge: counts cycles to out_valid,
    // compares against the scoreboard, then accepts the result.
    task automatic recv(input int sel, input string tag, input int lat_exp);
        int   n = 0;
        exp_t e;
        logic v;
        v = (sel == 0) ? ov : ov8;
        while (v !== 1'b1 && n < 200) begin
            tick(); n++;
            v = (sel == 0) ? ov : ov8;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat_exp));
        if (sel == 0) begin
            chk({tag, "_sb"}, 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({tag, "_bcd"}, 64'(bcd), 64'(e.bcd[23:0]));
                chk({tag, "_nz"},  64'(nz),  64'(e.nz[5:0]));
                chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
            end
            ordy = 1'b1; tick(); ordy = 1'b0;
            chk({tag, "_valid_drop"}, 64'(ov), 64'd0);
            chk({tag, "_bcd_hold"}, 64'(bcd), 64'(e.bcd[23:0]));
        end else begin
            chk({tag, "_sb"}, 64'(q8.size() > 0), 64'd1);
            if (q8.size() > 0) begin
                e = q8.pop_front();
                chk({tag, "_bcd"}, 64'(bcd8), 64'(e.bcd[7:0]));
                chk({tag, "_nz"},  64'(nz8),  64'(e.nz[1:0]));
                chk({tag, "_ovf"}, 64'(ovf8), 64'(e.ovf));
            end
            ordy8 = 1'b1; tick(); ordy8 = 1'b0;
            chk({tag, "_valid_drop"}, 64'(ov8), 64'd0);
        end
    endtask

    initial begin
        logic [23:0] bcd0;
        logic        stable;
        int          n;
        exp_t        e;
        longint unsigned vals [7] = '{0, 12345, 999999, 1000000, 20'hFFFFF, 1, 100000};

        rst_n = 1'b0;
        iv = 1'b0; id = '0; ordy = 1'b0;
        iv8 = 1'b0; id8 = '0; ordy8 = 1'b0;
        repeat (3) tick();

        // reset state
        chk("rst_out_valid", 64'(ov),  64'd0);
        chk("rst_bcd",       64'(bcd), 64'd0);
        chk("rst_nz",        64'(nz),  64'd1);
        chk("rst_ovf",       64'(ovf), 64'd0);
        chk("rst_nz8",       64'(nz8), 64'd1);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready",  64'(ir),  64'd1);

        // main conversions and overflow boundaries
        foreach (vals[i]) begin
            send(0, vals[i]);
            recv(0, "conv", 20);
        end

        // backpressure: result held 50 cycles, second request not taken
        send(0, 777);
        n = 0;
        while (ov !== 1'b1 && n < 200) begin tick(); n++; end
        chk("bp_latency", 64'(n), 64'd20);
        bcd0 = bcd;
        iv = 1'b1; id = 20'd54321;
        stable = 1'b1;
        repeat (50) begin
            tick();
            if (ov !== 1'b1 || bcd !== bcd0 || ir !== 1'b0) stable = 1'b0;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        e = q.pop_front();
        chk("bp_bcd", 64'(bcd), 64'(e.bcd[23:0]));
        ordy = 1'b1;
        tick();
        ordy = 1'b0;
        chk("bp_release_valid", 64'(ov), 64'd0);
        chk("bp_not_taken_in_done", 64'(ir), 64'd1);
        tick();
        iv = 1'b0; id = '0;
        q.push_back(model(54321, 6));
        recv(0, "bp2", 20);

        // reset mid-SHIFT aborts the conversion
        send(0, 123456);
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        chk("abort_valid", 64'(ov),  64'd0);
        chk("abort_bcd",   64'(bcd), 64'd0);
        chk("abort_ready", 64'(ir),  64'd1);
        chk("abort_nz",    64'(nz),  64'd1);
        q.delete();
        rst_n = 1'b1;
        tick();
        send(0, 42);
        recv(0, "post_abort", 20);

        // small configuration
        send(1, 255);
        recv(1, "w8_255", 8);
        send(1, 99);
        recv(1, "w8_99", 8);
        send(1, 7);
        recv(1, "w8_7", 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
